// File: rtl/bitop_arbiter.sv
// bitop_arbiter: shares one WIDTH-bit bitwise logic unit among four requesters
// and returns results through a single registered result slot (EMPTY/FULL).
// Configuration macro BITOP_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration. When it is left undefined, requester 0 always has the highest
// priority and requester 3 the lowest.
module bitop_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         req_valid,
  output logic [3:0]         req_ready,
  input  logic [7:0]         req_op,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
  output logic [WIDTH-1:0]   rsp_data
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_r;
  logic [1:0]       id_r;
  logic [WIDTH-1:0] data_r;
`ifdef BITOP_ARB_ROUND_ROBIN_EN
  logic [1:0]       ptr_r;
`endif

  logic             accept_s;
  logic             grant_s;
  logic [1:0]       grant_idx_s;
  logic [3:0]       ready_s;
  logic             xfer_s;
  logic [1:0]       sel_op_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [WIDTH-1:0] result_s;

  // Bitwise logic unit: 00 AND, 01 OR, 10 XOR, 11 XNOR.
  function automatic logic [WIDTH-1:0] bitop(input logic [1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      2'b11:   r = ~(a ^ b);
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Pick the winning requester among those presenting a valid request.
  always_comb begin : arb_pick
    logic [1:0] cand;
    grant_s     = 1'b0;
    grant_idx_s = 2'd0;
    cand        = 2'd0;
`ifdef BITOP_ARB_ROUND_ROBIN_EN
    // Search upward from the pointer, wrapping modulo 4.
    for (int k = 0; k < 4; k++) begin
      cand = ptr_r + k[1:0];
      if (!grant_s && req_valid[cand]) begin
        grant_s     = 1'b1;
        grant_idx_s = cand;
      end else begin
        grant_s     = grant_s;
      end
    end
`else
    // Descending scan so that the lowest valid index is the last one written.
    for (int k = 3; k >= 0; k--) begin
      cand = k[1:0];
      if (req_valid[cand]) begin
        grant_s     = 1'b1;
        grant_idx_s = cand;
      end else begin
        grant_s     = grant_s;
      end
    end
`endif
  end

  // The slot can take a new result when it is empty or is being drained this cycle.
  always_comb begin
    accept_s = (state_r == ST_EMPTY) || rsp_ready;
    ready_s  = 4'b0000;
    if (!reset && accept_s && grant_s) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = 4'b0000;
    end
  end

  assign req_ready = ready_s;
  assign xfer_s    = |ready_s;

  // Route the granted requester's opcode and operands to the shared logic unit.
  always_comb begin
    case (grant_idx_s)
      2'd0: begin
        sel_op_s = req_op[1:0];
        sel_a_s  = req_a[WIDTH-1:0];
        sel_b_s  = req_b[WIDTH-1:0];
      end
      2'd1: begin
        sel_op_s = req_op[3:2];
        sel_a_s  = req_a[2*WIDTH-1:WIDTH];
        sel_b_s  = req_b[2*WIDTH-1:WIDTH];
      end
      2'd2: begin
        sel_op_s = req_op[5:4];
        sel_a_s  = req_a[3*WIDTH-1:2*WIDTH];
        sel_b_s  = req_b[3*WIDTH-1:2*WIDTH];
      end
      2'd3: begin
        sel_op_s = req_op[7:6];
        sel_a_s  = req_a[4*WIDTH-1:3*WIDTH];
        sel_b_s  = req_b[4*WIDTH-1:3*WIDTH];
      end
      default: begin
        sel_op_s = req_op[1:0];
        sel_a_s  = req_a[WIDTH-1:0];
        sel_b_s  = req_b[WIDTH-1:0];
      end
    endcase
    result_s = bitop(sel_op_s, sel_a_s, sel_b_s);
  end

  // Result slot: load on a grant, empty when drained with no reload, otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_EMPTY;
      id_r    <= 2'd0;
      data_r  <= {WIDTH{1'b0}};
    end else if (xfer_s) begin
      state_r <= ST_FULL;
      id_r    <= grant_idx_s;
      data_r  <= result_s;
    end else if ((state_r == ST_FULL) && rsp_ready) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_r;
    end
  end

`ifdef BITOP_ARB_ROUND_ROBIN_EN
  // Round-robin pointer moves past the winner, and only when a transfer happens.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_r <= 2'd0;
    end else if (xfer_s) begin
      ptr_r <= grant_idx_s + 2'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  assign rsp_valid = (state_r == ST_FULL);
  assign rsp_id    = id_r;
  assign rsp_data  = data_r;

endmodule

// File: tb/tb_bitop_arbiter.sv
// Self-checking bench for bitop_arbiter: directed scenarios plus a randomized
// run, all checked against a transaction-level model of the result slot.
module tb_bitop_arbiter;
  localparam int W = 32;
`ifdef BITOP_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic [3:0]     req_valid;
  logic [3:0]     req_ready;
  logic [7:0]     req_op;
  logic [4*W-1:0] req_a;
  logic [4*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: one result slot plus the arbitration pointer.
  logic         m_valid;
  logic [1:0]   m_id;
  logic [W-1:0] m_data;
  int           m_ptr;
  int           m_gnt;

  bitop_arbiter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // Index the model grants this cycle, or -1 when nobody is granted.
  function automatic int ref_pick();
    int i;
    if (reset) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 0; k < 4; k++) begin
      i = RR_EN ? (m_ptr + k) % 4 : k;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] ref_ready();
    int g;
    logic [3:0] r;
    g = ref_pick();
    r = 4'b0000;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance the model by one rising edge using the inputs presented at it.
  task automatic model_clock();
    int g;
    g = ref_pick();
    m_gnt = g;
    if (reset) begin
      m_valid = 1'b0; m_id = 2'd0; m_data = '0; m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_id    = g[1:0];
      m_data  = ref_op(req_op[2*g +: 2], req_a[W*g +: W], req_b[W*g +: W]);
      m_ptr   = RR_EN ? (g + 1) % 4 : 0;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: model follows the edge, then return on the falling edge for driving.
  task automatic tick();
    @(posedge clock);
    model_clock();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
    req_op = '0; req_a = '0; req_b = '0;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    tick(); tick();
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ready_hold got=%b exp=0000", req_ready);
    end
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== '0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b id=%0d d=%h exp v=0 id=0 d=0", rsp_valid, rsp_id, rsp_data);
    end
    reset = 1'b0; req_valid = 4'b0000;
  endtask

  task automatic test_xnor();
    req_valid = 4'b0001; req_op = 8'b0000_0011; rsp_ready = 1'b1;
    req_a[W-1:0] = 32'hFFFF0000; req_b[W-1:0] = 32'h0F0F0F0F;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL xnor_ready got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h0F0FF0F0) begin
      miscompares++;
      $display("FAIL xnor_rsp got v=%b id=%0d d=%h exp v=1 id=0 d=0f0ff0f0", rsp_valid, rsp_id, rsp_data);
    end
    tick();
  endtask

  task automatic test_opcodes();
    logic [W-1:0] exp_tab [3];
    exp_tab[0] = 32'h88888888; exp_tab[1] = 32'hEEEEEEEE; exp_tab[2] = 32'h66666666;
    rsp_ready = 1'b1; req_valid = 4'b0100;
    req_a[3*W-1:2*W] = 32'hAAAAAAAA; req_b[3*W-1:2*W] = 32'hCCCCCCCC;
    for (int op = 0; op < 3; op++) begin
      req_op[5:4] = op[1:0];
      tick();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== exp_tab[op]) begin
        miscompares++;
        $display("FAIL opcode_%0d got v=%b id=%0d d=%h exp v=1 id=2 d=%h", op, rsp_valid, rsp_id, rsp_data, exp_tab[op]);
      end
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_hold();
    logic [1:0]   hold_id;
    logic [W-1:0] hold_data;
    rsp_ready = 1'b1; req_valid = 4'b0010; req_op[3:2] = 2'b10;
    req_a[2*W-1:W] = 32'h12345678; req_b[2*W-1:W] = 32'h0000FFFF;
    tick();
    hold_id = m_id; hold_data = m_data;
    rsp_ready = 1'b0; req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (req_ready !== 4'b0000) begin
        miscompares++; $display("FAIL hold_ready cyc=%0d got=%b exp=0000", c, req_ready);
      end
      tick();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== hold_id || rsp_data !== hold_data) begin
        miscompares++;
        $display("FAIL hold_rsp cyc=%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", c, rsp_valid, rsp_id, rsp_data, hold_id, hold_data);
      end
    end
    req_valid = 4'b0000; rsp_ready = 1'b1;
    tick();
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL drain_empty got v=%b exp v=0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_id;
    reset = 1'b1; tick(); reset = 1'b0;
    rsp_ready = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_op[2*i +: 2] = i[1:0];
      req_a[W*i +: W]  = $urandom;
      req_b[W*i +: W]  = $urandom;
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      exp_id = RR_EN ? 2'(c % 4) : 2'd0;
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== m_data) begin
        miscompares++;
        $display("FAIL b2b cyc=%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", c, rsp_valid, rsp_id, rsp_data, exp_id, m_data);
      end
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] pend;
    logic [3:0] exp_ready;
    pend = 4'b0000; req_valid = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_op[2*i +: 2] = 2'($urandom_range(0, 3));
          req_a[W*i +: W]  = $urandom;
          req_b[W*i +: W]  = $urandom;
          pend[i] = req_valid[i];
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = ref_ready();
      vectors++;
      if (req_ready !== exp_ready) begin
        miscompares++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_ready);
      end
      tick();
      if (m_gnt >= 0) pend[m_gnt] = 1'b0;
      vectors++;
      if (rsp_valid !== m_valid || (m_valid && (rsp_id !== m_id || rsp_data !== m_data))) begin
        miscompares++;
        $display("FAIL rand_rsp cyc=%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h", c, rsp_valid, rsp_id, rsp_data, m_valid, m_id, m_data);
      end
    end
    req_valid = 4'b0000; rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1; req_valid = 4'b0001; req_op[1:0] = 2'b01;
    req_a[W-1:0] = 32'h00FF00FF; req_b[W-1:0] = 32'h0F000F00;
    tick();
    rsp_ready = 1'b0; req_valid = 4'b1010; reset = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL midreset_ready got=%b exp=0000", req_ready);
    end
    tick();
    reset = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== '0) begin
      miscompares++;
      $display("FAIL midreset_state got v=%b id=%0d d=%h exp v=0 id=0 d=0", rsp_valid, rsp_id, rsp_data);
    end
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++; $display("FAIL midreset_grant got=%b exp=0010", req_ready);
    end
    tick();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      miscompares++; $display("FAIL midreset_rsp got v=%b id=%0d exp v=1 id=1", rsp_valid, rsp_id);
    end
    req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_xnor();
    test_opcodes();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bitop_arbiter.md
BITOP_ARBITER -- requirements
Module: bitop_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req_valid  input  4  request valid per requester i (bit i).
REQ-005 Port: req_ready  output  4  request accepted per requester i this cycle.
REQ-006 Port: req_op  input  8  2-bit opcode per requester (bits 2i+1:2i): 00 AND, 01 OR, 10 XOR, 11 XNOR.
REQ-007 Port: req_a  input  4*WIDTH  operand A per requester (slice i at bits WIDTH*i+WIDTH-1:WIDTH*i).
REQ-008 Port: req_b  input  4*WIDTH  operand B per requester, same slicing.
REQ-009 Port: rsp_valid  output  1  result register holds a valid result.
REQ-010 Port: rsp_ready  input  1  consumer accepts result this cycle.
REQ-011 Port: rsp_id  output  2  index of requester that produced rsp_data.
REQ-012 Port: rsp_data  output  WIDTH  bitwise result, registered.

Function
REQ-013 The block SHALL time-share one WIDTH-bit bitwise logic unit among 4 requesters.
REQ-014 The block SHALL keep a single result register with two states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
REQ-015 accept SHALL be defined as (state EMPTY) or (rsp_valid and rsp_ready).
REQ-016 When accept=1 and req_valid!=0, exactly one req_ready bit SHALL be 1, for the granted requester; otherwise req_ready=0000.
REQ-017 req_ready SHALL be combinational from req_valid, state, rsp_ready, and priority pointer.
REQ-018 On a granted transfer, the next cycle SHALL have rsp_valid=1, rsp_id=granted index, and rsp_data=op(req_a[i], req_b[i]) computed per bit (latency 1).
REQ-019 Opcode results SHALL be: 00 A&B, 01 A|B, 10 A^B, 11 ~(A^B), all bits independent.
REQ-020 While FULL and rsp_ready=0, rsp_valid, rsp_id, and rsp_data SHALL hold stable.
REQ-021 FULL with rsp_ready=1 and no grant SHALL go EMPTY; FULL with rsp_ready=1 and a grant SHALL reload (back-to-back, no bubble).
REQ-022 In EMPTY, rsp_data and rsp_id SHALL retain their last values.
REQ-023 Requesters not granted SHALL see req_ready=0 and must hold their request; the block SHALL NOT queue requests.
REQ-024 Arbitration SHALL follow REQ-031/REQ-032.
REQ-025 The priority pointer SHALL update only on a granted transfer.

Reset
REQ-026 When reset=1 at a clock edge, the block SHALL set state EMPTY, rsp_valid=0, rsp_id=0, rsp_data=0, and priority pointer=0.
REQ-027 While reset=1, req_ready SHALL be 0000.
REQ-028 Reset mid-operation SHALL discard any pending result without a rsp handshake.
REQ-029 On the first cycle after reset deasserts, the block SHALL grant per pointer=0.

Configuration
REQ-030 Macro BITOP_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-031 With BITOP_ARB_ROUND_ROBIN_EN defined: round-robin; search starts at pointer p, ascending mod 4; after grant to i, p becomes (i+1) mod 4.
REQ-032 Without it: fixed priority, requester 0 highest, 3 lowest; pointer unused and held at 0.

Verification
REQ-033 Reset, then req_valid=0001, op=11, A=FFFF0000, B=0F0F0F0F, rsp_ready=1 -> req_ready=0001; next cycle rsp_valid=1, rsp_id=0, rsp_data=0F0FF0F0.
REQ-034 rsp_ready=0 with FULL for 5 cycles, req_valid=1111 -> req_ready=0000 throughout; rsp_data/rsp_id unchanged.
REQ-035 RR build, all 4 valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 with one result per cycle; fixed build -> rsp_id 0 every cycle.
REQ-036 Opcodes 00/01/10 with A=AAAAAAAA, B=CCCCCCCC -> rsp_data 88888888 / EEEEEEEE / 66666666.
REQ-037 Reset asserted while FULL -> next cycle rsp_valid=0, rsp_data=0, rsp_id=0; RR pointer restarts at 0 (req_valid=1010 grants 1 first).
